palette_bank: RTL and testbench
===============================

PALETTE_BANK -- requirements
Module: palette_bank

Interface
REQ-001 Parameter INDEX_W, default 6, SHALL set the colour index width (2^INDEX_W entries per bank).
REQ-002 Parameter BANKS, default 4, SHALL set the palette bank count (power of two, >=2; BW = log2(BANKS)).
REQ-003 Parameter CH_W, default 4, SHALL set the bits per colour channel.
REQ-004 Clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-005 Reset_n  in  1  reset; asynchronous, active-low.
REQ-006 pix_valid  in  1  pixel index qualifier (high during active video).
REQ-007 pix_index  in  INDEX_W  colour index to look up.
REQ-008 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-009 wr_valid / wr_ready  in / out  1 / 1  palette write handshake.
REQ-010 wr_bank, wr_index, wr_rgb  in  BW, INDEX_W, 3*CH_W  write target and colour {R,G,B}.
REQ-011 sel_valid, sel_bank  in  1, BW  request to change the displayed bank.
REQ-012 fade_target  in  CH_W  requested fade level (0 = full brightness).
REQ-013 red, green, blue  out  CH_W each  scaled colour output.
REQ-014 out_valid  out  1  qualifies red/green/blue.
REQ-015 active_bank  out  BW  bank currently displayed; fade_level  out  CH_W  current fade.

Function
REQ-016 Storage: BANKS x 2^INDEX_W words of 3*CH_W bits; read path SHALL be synchronous.
REQ-017 Latency: pix_valid/pix_index at edge N SHALL produce out_valid and rgb at edge N+2 (stage 1 lookup, stage 2 fade scale); one pixel per cycle, no stalls.
REQ-018 When out_valid is 0, red/green/blue SHALL be 0.
REQ-019 A write SHALL occur on an edge where wr_valid & wr_ready; the new entry SHALL be visible to a lookup issued on the following cycle or later.
REQ-020 wr_ready SHALL be 0 only when wr_bank == active_bank and pix_valid == 1 (tear protection); writes to other banks are always ready.
REQ-021 wr_valid held with wr_ready low SHALL not write; write fields SHALL be held stable until accepted.
REQ-022 sel_valid SHALL latch sel_bank into a pending register (last request wins); the pending bank SHALL become active_bank on the frame_start edge, never mid-frame.
REQ-023 sel_valid and frame_start on the same edge: the new sel_bank SHALL be applied at that edge.
REQ-024 On each frame_start, fade_level SHALL step by 1 toward fade_target (+1 if lower, -1 if higher, hold if equal); no wrap.
REQ-025 Scaling: scale = 2^CH_W - fade_level (CH_W+1 bits); out = (ch * scale) >> CH_W, full-width product, truncated; fade_level 0 SHALL give the stored value exactly.
REQ-026 fade_level and active_bank SHALL be sampled in stage 1 so that one pixel uses a single consistent bank/fade pair.

Reset
REQ-027 Reset_n low SHALL immediately clear out_valid, red, green, blue, pipeline valids, active_bank, pending bank and fade_level to 0.
REQ-028 Palette contents SHALL reset to 0 in every bank; wr_ready SHALL be 1 after reset when the REQ-020 condition is false.
REQ-029 Reset asserted mid-frame or mid-fade SHALL discard in-flight pixels; no out_valid SHALL appear until 2 cycles after the first pix_valid following release.

Verification
REQ-030 Write bank0 idx5 = 0xC22, then pix_index 5 with pix_valid -> out rgb = C,2,2 with out_valid exactly 2 cycles later.
REQ-031 pix_valid=1, active_bank=0, write to bank0 -> wr_ready=0, no write; same write to bank1 -> accepted same cycle.
REQ-032 sel_bank=2 mid-frame -> active_bank stays 0 until frame_start, then 2; the next pixel reads bank2 contents.
REQ-033 fade_target=15 from 0 -> fade_level 1,2,...,15 on successive frame_starts; stored 0xF at fade 8 -> output 0x7, at fade 15 -> 0x0.
REQ-034 Back-to-back indices 0..63 on consecutive cycles -> 64 consecutive out_valid cycles, values in order, no gaps.
REQ-035 Reset_n pulled low with 2 pixels in flight and fade_level=6 -> out_valid=0, fade_level=0, palette reads 0 afterward.

Source files
------------

// File: rtl/palette_bank_if.sv
// Pixel lookup, palette write, bank select and fade signals for palette_bank.
// The master side drives requests; the slave side is the palette itself.
interface palette_bank_if #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned BANKS   = 4,
    parameter int unsigned CH_W    = 4
);
    localparam int unsigned BW = $clog2(BANKS);

    logic                 pix_valid;
    logic [INDEX_W-1:0]   pix_index;
    logic                 frame_start;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [BW-1:0]        wr_bank;
    logic [INDEX_W-1:0]   wr_index;
    logic [3*CH_W-1:0]    wr_rgb;
    logic                 sel_valid;
    logic [BW-1:0]        sel_bank;
    logic [CH_W-1:0]      fade_target;
    logic [CH_W-1:0]      red;
    logic [CH_W-1:0]      green;
    logic [CH_W-1:0]      blue;
    logic                 out_valid;
    logic [BW-1:0]        active_bank;
    logic [CH_W-1:0]      fade_level;

    modport master (
        output pix_valid, pix_index, frame_start,
        output wr_valid, wr_bank, wr_index, wr_rgb,
        output sel_valid, sel_bank, fade_target,
        input  wr_ready, red, green, blue, out_valid, active_bank, fade_level
    );

    modport slave (
        input  pix_valid, pix_index, frame_start,
        input  wr_valid, wr_bank, wr_index, wr_rgb,
        input  sel_valid, sel_bank, fade_target,
        output wr_ready, red, green, blue, out_valid, active_bank, fade_level
    );
endinterface

// File: rtl/palette_bank.sv
// Multi-bank colour palette with frame-synchronous bank switching and fade.
// Two-stage pipeline: registered lookup, then registered fade scaling.
module palette_bank #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned BANKS   = 4,
    parameter int unsigned CH_W    = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    palette_bank_if.slave  bus
);
    localparam int unsigned BW    = $clog2(BANKS);
    localparam int unsigned DEPTH = 1 << INDEX_W;
    localparam int unsigned RGB_W = 3 * CH_W;
    localparam logic [CH_W:0] FULL_SCALE = {1'b1, {CH_W{1'b0}}};

    logic [RGB_W-1:0] mem_q [BANKS][DEPTH];

    logic [BW-1:0]    active_bank_q, active_bank_d;
    logic [BW-1:0]    pend_bank_q, pend_bank_d;
    logic [CH_W-1:0]  fade_q, fade_d;

    logic             s1_valid_q;
    logic [RGB_W-1:0] s1_rgb_q;
    logic [CH_W-1:0]  s1_fade_q;

    logic             out_valid_q;
    logic [CH_W-1:0]  red_q, green_q, blue_q;
    logic [CH_W-1:0]  red_d, green_d, blue_d;
    logic [CH_W:0]    scale;

    logic wr_ready;
    logic wr_en;

    // Writing the bank being scanned out is held off only while pixels are live.
    assign wr_ready = !(bus.pix_valid && (bus.wr_bank == active_bank_q));
    assign wr_en    = bus.wr_valid && wr_ready;

    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                 input logic [CH_W:0]   sc);
        return CH_W'(({{CH_W{1'b0}}, ch} * {{(CH_W-1){1'b0}}, sc}) >> CH_W);
    endfunction

    always_comb begin
        pend_bank_d   = pend_bank_q;
        active_bank_d = active_bank_q;
        fade_d        = fade_q;
        if (bus.sel_valid) begin
            pend_bank_d = bus.sel_bank;
        end
        if (bus.frame_start) begin
            active_bank_d = pend_bank_d;
            if (fade_q < bus.fade_target) begin
                fade_d = fade_q + 1'b1;
            end else if (fade_q > bus.fade_target) begin
                fade_d = fade_q - 1'b1;
            end
        end
    end

    always_comb begin
        scale   = FULL_SCALE - {1'b0, s1_fade_q};
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (s1_valid_q) begin
            red_d   = scale_ch(s1_rgb_q[RGB_W-1 -: CH_W], scale);
            green_d = scale_ch(s1_rgb_q[2*CH_W-1 -: CH_W], scale);
            blue_d  = scale_ch(s1_rgb_q[CH_W-1:0], scale);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    mem_q[b][d] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[bus.wr_bank][bus.wr_index] <= bus.wr_rgb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_bank_q <= '0;
            pend_bank_q   <= '0;
            fade_q        <= '0;
            s1_valid_q    <= 1'b0;
            s1_rgb_q      <= '0;
            s1_fade_q     <= '0;
            out_valid_q   <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            active_bank_q <= active_bank_d;
            pend_bank_q   <= pend_bank_d;
            fade_q        <= fade_d;
            // Bank and fade are captured with the pixel so both stages agree.
            s1_valid_q    <= bus.pix_valid;
            s1_rgb_q      <= mem_q[active_bank_q][bus.pix_index];
            s1_fade_q     <= fade_q;
            out_valid_q   <= s1_valid_q;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.active_bank = active_bank_q;
    assign bus.fade_level  = fade_q;
endmodule

// File: tb/tb_palette_bank.sv
// Directed self-checking bench for palette_bank: lookup latency, tear
// protection, bank switching, fade scaling, streaming and reset recovery.
module tb_palette_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    palette_bank_if #(.INDEX_W(6), .BANKS(4), .CH_W(4)) bus ();

    palette_bank #(.INDEX_W(6), .BANKS(4), .CH_W(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    function automatic logic [11:0] b2b_rgb(input int unsigned i);
        return 12'((i * 53) ^ 12'h9C6);
    endfunction

    task automatic do_write(input logic [1:0] b, input logic [5:0] idx, input logic [11:0] rgb);
        @(negedge clk);
        bus.wr_bank = b; bus.wr_index = idx; bus.wr_rgb = rgb; bus.wr_valid = 1'b1;
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic frame_pulse(input logic sel, input logic [1:0] sb);
        @(negedge clk);
        bus.frame_start = 1'b1; bus.sel_valid = sel; bus.sel_bank = sb;
        @(negedge clk);
        bus.frame_start = 1'b0; bus.sel_valid = 1'b0;
    endtask

    task automatic lookup(input logic [5:0] idx, output logic early_v, output logic v,
                          output logic [11:0] rgb);
        @(negedge clk);
        bus.pix_valid = 1'b1; bus.pix_index = idx;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        early_v = bus.out_valid;
        @(negedge clk);
        v = bus.out_valid;
        rgb = {bus.red, bus.green, bus.blue};
    endtask

    task automatic test_reset();
        bus.pix_valid = 1'b0; bus.pix_index = '0; bus.frame_start = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_bank = '0; bus.wr_index = '0; bus.wr_rgb = '0;
        bus.sel_valid = 1'b0; bus.sel_bank = '0; bus.fade_target = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if ({bus.red, bus.green, bus.blue} !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", {bus.red, bus.green, bus.blue}); end
        total++; if (bus.active_bank !== 2'd0) begin bad++; $display("FAIL reset_active_bank got=%0d exp=0", bus.active_bank); end
        total++; if (bus.fade_level !== 4'd0) begin bad++; $display("FAIL reset_fade got=%0d exp=0", bus.fade_level); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
    endtask

    task automatic test_write_lookup();
        logic ev, v;
        logic [11:0] rgb;
        do_write(2'd0, 6'd5, 12'hC22);
        lookup(6'd5, ev, v, rgb);
        total++; if (ev !== 1'b0) begin bad++; $display("FAIL wl_early_valid got=%b exp=0", ev); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL wl_valid got=%b exp=1", v); end
        total++; if (rgb !== 12'hC22) begin bad++; $display("FAIL wl_rgb got=%h exp=C22", rgb); end
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wl_valid_drop got=%b exp=0", bus.out_valid); end
        total++; if ({bus.red, bus.green, bus.blue} !== 12'h000) begin bad++; $display("FAIL wl_rgb_zero got=%h exp=000", {bus.red, bus.green, bus.blue}); end
    endtask

    task automatic test_tear();
        logic ev, v;
        logic [11:0] rgb;
        @(negedge clk);
        bus.pix_valid = 1'b1; bus.pix_index = 6'd0;
        bus.wr_bank = 2'd0; bus.wr_index = 6'd7; bus.wr_rgb = 12'hABC; bus.wr_valid = 1'b1;
        #1;
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL tear_ready_active got=%b exp=0", bus.wr_ready); end
        @(negedge clk);
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL tear_ready_held got=%b exp=0", bus.wr_ready); end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        bus.wr_bank = 2'd1; bus.wr_valid = 1'b1;
        #1;
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL tear_ready_other got=%b exp=1", bus.wr_ready); end
        @(negedge clk);
        bus.wr_valid = 1'b0; bus.pix_valid = 1'b0; bus.wr_bank = 2'd0;
        #1;
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL tear_ready_blank got=%b exp=1", bus.wr_ready); end
        lookup(6'd7, ev, v, rgb);
        total++; if (rgb !== 12'h000 || v !== 1'b1) begin bad++; $display("FAIL tear_no_write got=%h/%b exp=000/1", rgb, v); end
    endtask

    task automatic test_bank_select();
        logic ev, v;
        logic [11:0] rgb;
        do_write(2'd2, 6'd3, 12'h5A7);
        do_write(2'd0, 6'd3, 12'h111);
        @(negedge clk);
        bus.pix_valid = 1'b1; bus.pix_index = 6'd3; bus.sel_valid = 1'b1; bus.sel_bank = 2'd2;
        @(negedge clk);
        bus.sel_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.active_bank !== 2'd0) begin bad++; $display("FAIL sel_midframe_bank got=%0d exp=0", bus.active_bank); end
        total++; if ({bus.red, bus.green, bus.blue} !== 12'h111) begin bad++; $display("FAIL sel_midframe_rgb got=%h exp=111", {bus.red, bus.green, bus.blue}); end
        bus.pix_valid = 1'b0;
        frame_pulse(1'b0, 2'd0);
        total++; if (bus.active_bank !== 2'd2) begin bad++; $display("FAIL sel_after_frame got=%0d exp=2", bus.active_bank); end
        lookup(6'd3, ev, v, rgb);
        total++; if (rgb !== 12'h5A7) begin bad++; $display("FAIL sel_bank2_rgb got=%h exp=5A7", rgb); end
        frame_pulse(1'b1, 2'd1);
        total++; if (bus.active_bank !== 2'd1) begin bad++; $display("FAIL sel_same_edge got=%0d exp=1", bus.active_bank); end
        lookup(6'd7, ev, v, rgb);
        total++; if (rgb !== 12'hABC) begin bad++; $display("FAIL sel_bank1_rgb got=%h exp=ABC", rgb); end
        @(negedge clk);
        bus.sel_valid = 1'b1; bus.sel_bank = 2'd3;
        @(negedge clk);
        bus.sel_bank = 2'd0;
        @(negedge clk);
        bus.sel_valid = 1'b0;
        total++; if (bus.active_bank !== 2'd1) begin bad++; $display("FAIL sel_pending_hold got=%0d exp=1", bus.active_bank); end
        frame_pulse(1'b0, 2'd3);
        total++; if (bus.active_bank !== 2'd0) begin bad++; $display("FAIL sel_last_wins got=%0d exp=0", bus.active_bank); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_rgb;
        logic exp_v;
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_bank = 2'd3;
        for (int i = 0; i < 64; i++) begin
            bus.wr_index = 6'(i); bus.wr_rgb = b2b_rgb(unsigned'(i));
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        frame_pulse(1'b1, 2'd3);
        for (int k = 0; k <= 66; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp_v   = (k < 66);
                exp_rgb = exp_v ? b2b_rgb(unsigned'(k - 2)) : 12'h000;
                total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, bus.out_valid, exp_v); end
                total++; if ({bus.red, bus.green, bus.blue} !== exp_rgb) begin bad++; $display("FAIL b2b_rgb k=%0d got=%h exp=%h", k, {bus.red, bus.green, bus.blue}, exp_rgb); end
            end
            if (k < 64) begin
                bus.pix_valid = 1'b1; bus.pix_index = 6'(k);
            end else begin
                bus.pix_valid = 1'b0;
            end
        end
    endtask

    task automatic test_fade();
        logic ev, v;
        logic [11:0] rgb;
        do_write(2'd3, 6'd9, 12'hF84);
        bus.fade_target = 4'd15;
        for (int i = 1; i <= 15; i++) begin
            frame_pulse(1'b0, 2'd0);
            total++; if (bus.fade_level !== 4'(i)) begin bad++; $display("FAIL fade_up got=%0d exp=%0d", bus.fade_level, i); end
            if (i == 8) begin
                lookup(6'd9, ev, v, rgb);
                total++; if (rgb !== 12'h742) begin bad++; $display("FAIL fade8_rgb got=%h exp=742", rgb); end
            end
        end
        lookup(6'd9, ev, v, rgb);
        total++; if (rgb !== 12'h000 || v !== 1'b1) begin bad++; $display("FAIL fade15_rgb got=%h/%b exp=000/1", rgb, v); end
        frame_pulse(1'b0, 2'd0);
        total++; if (bus.fade_level !== 4'd15) begin bad++; $display("FAIL fade_no_wrap got=%0d exp=15", bus.fade_level); end
        bus.fade_target = 4'd13;
        frame_pulse(1'b0, 2'd0);
        total++; if (bus.fade_level !== 4'd14) begin bad++; $display("FAIL fade_down1 got=%0d exp=14", bus.fade_level); end
        frame_pulse(1'b0, 2'd0);
        total++; if (bus.fade_level !== 4'd13) begin bad++; $display("FAIL fade_down2 got=%0d exp=13", bus.fade_level); end
        lookup(6'd9, ev, v, rgb);
        total++; if (rgb !== 12'h210) begin bad++; $display("FAIL fade13_rgb got=%h exp=210", rgb); end
    endtask

    task automatic test_reset_midflight();
        logic ev, v;
        logic [11:0] rgb;
        bus.fade_target = 4'd6;
        repeat (7) frame_pulse(1'b0, 2'd0);
        total++; if (bus.fade_level !== 4'd6) begin bad++; $display("FAIL rst_pre_fade got=%0d exp=6", bus.fade_level); end
        @(negedge clk);
        bus.pix_valid = 1'b1; bus.pix_index = 6'd9;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        total++; if ({bus.out_valid, bus.red, bus.green, bus.blue} !== 13'h1952) begin bad++; $display("FAIL rst_pre_out got=%h exp=1952", {bus.out_valid, bus.red, bus.green, bus.blue}); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", bus.out_valid); end
        total++; if ({bus.red, bus.green, bus.blue} !== 12'h000) begin bad++; $display("FAIL rst_mid_rgb got=%h exp=000", {bus.red, bus.green, bus.blue}); end
        total++; if (bus.fade_level !== 4'd0) begin bad++; $display("FAIL rst_mid_fade got=%0d exp=0", bus.fade_level); end
        total++; if (bus.active_bank !== 2'd0) begin bad++; $display("FAIL rst_mid_bank got=%0d exp=0", bus.active_bank); end
        bus.pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_post_idle cyc=%0d got=%b exp=0", i, bus.out_valid); end
        end
        lookup(6'd5, ev, v, rgb);
        total++; if (ev !== 1'b0) begin bad++; $display("FAIL rst_post_early got=%b exp=0", ev); end
        total++; if ({v, rgb} !== 13'h1000) begin bad++; $display("FAIL rst_bank0_cleared got=%h exp=1000", {v, rgb}); end
        frame_pulse(1'b1, 2'd3);
        lookup(6'd9, ev, v, rgb);
        total++; if ({v, rgb} !== 13'h1000) begin bad++; $display("FAIL rst_bank3_cleared got=%h exp=1000", {v, rgb}); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_write_lookup();
        test_tear();
        test_bank_select();
        test_back_to_back();
        test_fade();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
